// File: rtl/rr_arbiter_n_if.sv
// Bus between N requesting masters and the round-robin arbiter.
// The optional lock line exists only when RR_ARB_LOCK_EN is defined.
interface rr_arbiter_n_if #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N-1:0]    ack;
  logic [ID_W-1:0] grant_id;
  logic            busy;
`ifdef RR_ARB_LOCK_EN
  logic            lock;

  modport master (output req, output lock, input ack, input grant_id, input busy);
  modport slave  (input req, input lock, output ack, output grant_id, output busy);
`else
  modport master (output req, input ack, input grant_id, input busy);
  modport slave  (input req, output ack, output grant_id, output busy);
`endif
endinterface

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with registered requests and a grant quantum.
// Requests are registered once, the grant is computed from the registered requests
// and registered again, giving two edges from req to ack.
// Optional feature macro: RR_ARB_LOCK_EN (adds a lock input that suspends quantum rotation).
module rr_arbiter_n #(
  parameter int N       = 4,
  parameter int QUANTUM = 2
) (
  input  logic           clock_i,
  input  logic           reset_i,
  rr_arbiter_n_if.slave  bus
);
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    ack_q, ack_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lock_w;

`ifdef RR_ARB_LOCK_EN
  assign lock_w = bus.lock;
`else
  assign lock_w = 1'b0;
`endif

  // Circular first-set search: returns {found, index}, scanning start, start+1, ... mod N.
  function automatic logic [ID_W:0] rr_search(input logic [N-1:0] v, input logic [ID_W-1:0] start);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] idx_t;
    int              idx;
    r = '0;
    // Scan from the far end so the position closest to start wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      idx_t = ID_W'(idx);
      if (v[idx_t]) r = {1'b1, idx_t};
    end
    return r;
  endfunction

  // Index successor with wrap N-1 -> 0.
  function automatic logic [ID_W-1:0] nxt_idx(input logic [ID_W-1:0] x);
    return (x == ID_W'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // Saturating hold counter increment; never wraps.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == QMAX) ? QMAX : c + 1'b1;
  endfunction

  logic [N-1:0]  own_oh;
  logic [N-1:0]  others;
  logic [ID_W:0] srch;
  logic          do_grant;
  logic [ID_W-1:0] new_id;

  // Next-state and grant decision from registered requests, owner, pointer and hold count.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    gid_d    = gid_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    do_grant = 1'b0;
    new_id   = '0;
    srch     = '0;
    own_oh   = N'(1) << gid_q;
    others   = req_q & ~own_oh;

    unique case (state_q)
      S_IDLE: begin
        if (|req_q) begin
          srch     = rr_search(req_q, ptr_q);
          do_grant = 1'b1;
          new_id   = srch[ID_W-1:0];
        end
      end
      S_OWN: begin
        if (!req_q[gid_q]) begin
          if (|others) begin
            // Owner released while others wait: hand off in the same edge, no bubble.
            srch     = rr_search(others, nxt_idx(gid_q));
            do_grant = 1'b1;
            new_id   = srch[ID_W-1:0];
          end else begin
            state_d = S_IDLE;
            ack_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (!(|others) || lock_w || (cnt_q < QMAX)) begin
          cnt_d = cnt_inc(cnt_q);
        end else begin
          srch     = rr_search(others, nxt_idx(gid_q));
          do_grant = 1'b1;
          new_id   = srch[ID_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_grant) begin
      state_d = S_OWN;
      ack_d   = N'(1) << new_id;
      gid_d   = new_id;
      busy_d  = 1'b1;
      cnt_d   = CNT_W'(1);
      ptr_d   = nxt_idx(new_id);
    end
  end

  // Request capture stage and grant state registers, cleared asynchronously.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      req_q   <= '0;
      state_q <= S_IDLE;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      req_q   <= bus.req;
      state_q <= state_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n with N=4, QUANTUM=2; expected values are hand-derived.
module tb_rr_arbiter_n;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rr_arbiter_n_if #(.N(N)) bus ();

  rr_arbiter_n #(.N(N), .QUANTUM(2)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled on the falling edge.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(bus.ack)), 32'd1);
    check("busy_eq", 32'(bus.busy), 32'(|bus.ack));
  end

  logic [N-1:0] seq3 [8];

  initial begin
    n_chk   = 0;
    n_err   = 0;
    bus.req = '0;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    rst = 1'b1;
    #12;
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_gid", 32'(bus.grant_id), 32'h0);
    step();
    rst = 1'b0;

    // Single requester: grant after two edges, never rotates, releases after two edges.
    bus.req = 4'b0010;
    step();
    check("single_lat1", 32'(bus.ack), 32'h0);
    step();
    check("single_ack", 32'(bus.ack), 32'h2);
    check("single_gid", 32'(bus.grant_id), 32'h1);
    check("single_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("single_hold", 32'(bus.ack), 32'h2);
    end
    bus.req = '0;
    step();
    check("single_rel1", 32'(bus.ack), 32'h2);
    step();
    check("single_rel2", 32'(bus.ack), 32'h0);
    check("single_rel_busy", 32'(bus.busy), 32'h0);
    check("single_gid_hold", 32'(bus.grant_id), 32'h1);

    // Pointer fairness: grant ch2, go idle, then search starts at ptr=3.
    bus.req = 4'b0100;
    step(); step();
    check("ptr_ch2", 32'(bus.ack), 32'h4);
    bus.req = '0;
    step(); step();
    check("ptr_idle", 32'(bus.ack), 32'h0);
    bus.req = 4'b1101;
    step(); step();
    check("ptr_fair", 32'(bus.ack), 32'h8);
    check("ptr_fair_gid", 32'(bus.grant_id), 32'h3);

    // Reset mid-grant: ptr is now 0, grant ch2 then reset between edges.
    bus.req = '0;
    step(); step();
    bus.req = 4'b0100;
    step(); step();
    check("mid_pre", 32'(bus.ack), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(bus.ack), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0011;
    step();
    check("mid_lat1", 32'(bus.ack), 32'h0);
    step();
    check("mid_ack", 32'(bus.ack), 32'h1);

    // Two-way contention, with and without lock.
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("lock_hold", 32'(bus.ack), 32'h1);
    end
    bus.lock = 1'b0;
    step();
    check("lock_rel", 32'(bus.ack), 32'h2);
`else
    step();
    check("rot_keep0", 32'(bus.ack), 32'h1);
    step();
    check("rot_to1", 32'(bus.ack), 32'h2);
    step();
    check("rot_keep1", 32'(bus.ack), 32'h2);
    step();
    check("rot_to0", 32'(bus.ack), 32'h1);
`endif

    // Full contention held from reset, then owner release hand-off on wrap.
    rst = 1'b1;
    bus.req = 4'b1111;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    step();
    check("fc_rst_ack", 32'(bus.ack), 32'h0);
    rst = 1'b0;
    step();
    check("fc_lat1", 32'(bus.ack), 32'h0);
    seq3[0] = 4'b0001; seq3[1] = 4'b0001; seq3[2] = 4'b0010; seq3[3] = 4'b0010;
    seq3[4] = 4'b0100; seq3[5] = 4'b0100; seq3[6] = 4'b1000; seq3[7] = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("fc_seq%0d", i), 32'(bus.ack), 32'(seq3[i]));
    end
    bus.req = 4'b1110;
    step();
    check("fc_wrap", 32'(bus.ack), 32'h1);
    step();
    check("handoff", 32'(bus.ack), 32'h2);
    check("handoff_gid", 32'(bus.grant_id), 32'h1);
    step();
    check("handoff_keep", 32'(bus.ack), 32'h2);
    step();
    check("handoff_rot", 32'(bus.ack), 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
